uart_tx_ctrl: RTL

// - Frame sequencer for the UART TX datapath (start, data, parity, CRC, stop).
// - Accepts bytes on a valid/ready handshake and holds the frame byte stable.
// - Drives the datapath's start command, state flags and state-change strobe; reads back its bit counter.
// - Sits between the host/byte source and the TX datapath; baud_tick_i is shared with the datapath trigger.

---
 rtl/uart_tx_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame sequencer for the UART TX datapath.
// Walks START -> DATA -> [PARITY] -> [CRC] -> STOP, one state change per
// baud tick at most, holding the frame byte stable on data_o for the whole
// frame. The datapath owns the bit counter; this block only reads it back.
// Handshake: a byte moves when tx_valid_i && tx_ready_o are both 1 on a
// rising clk_i edge; tx_valid_i may be held while tx_ready_o is 0 and the
// byte is then left untouched.
// Optional build macro UART_TX_PREFETCH_EN adds a one-entry holding register
// so the next byte can be accepted while a frame is in flight.
module uart_tx_ctrl #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       baud_tick_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  input  logic       parity_en_i,
  input  logic       crc_en_i,
  input  logic [4:0] bit_cnt_i,
  input  logic       start_tx_i,
  output logic [7:0] data_o,
  output logic       crc_en_o,
  output logic       tx_start_cmd_o,
  output logic       changed_tx_state_o,
  output logic       is_idle_o,
  output logic       is_start_o,
  output logic       is_data_o,
  output logic       is_parity_o,
  output logic       is_crc_o,
  output logic       is_stop_o,
  output logic       frame_done_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_CRC    = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [4:0] LAST_BYTE_CNT = 5'd7;
  localparam logic [4:0] LAST_STOP_CNT = 5'(STOP_BITS - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_is_idle;
  logic       r_is_start;
  logic       r_is_data;
  logic       r_is_parity;
  logic       r_is_crc;
  logic       r_is_stop;
  logic       r_frame_done;
  logic       r_pending;
  logic       r_start_cmd;
  logic       r_par_q;
  logic       r_crc_en;
  logic [7:0] r_data;

  logic       w_launch;
  logic       w_frame_end;
  logic       w_load_frame;
  logic [7:0] w_load_data;
  logic       w_load_crc;
  logic       w_load_par;

  // Next-state decode; every transition is qualified by baud_tick_i except
  // recovery from an unused encoding, which returns to IDLE at once.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (baud_tick_i && r_pending && start_tx_i) w_next_state = S_START;
      end
      S_START: begin
        if (baud_tick_i) w_next_state = S_DATA;
      end
      S_DATA: begin
        if (baud_tick_i && (bit_cnt_i == LAST_BYTE_CNT)) begin
          if (r_par_q)       w_next_state = S_PARITY;
          else if (r_crc_en) w_next_state = S_CRC;
          else               w_next_state = S_STOP;
        end
      end
      S_PARITY: begin
        if (baud_tick_i) w_next_state = r_crc_en ? S_CRC : S_STOP;
      end
      S_CRC: begin
        if (baud_tick_i && (bit_cnt_i == LAST_BYTE_CNT)) w_next_state = S_STOP;
      end
      S_STOP: begin
        if (baud_tick_i && (bit_cnt_i == LAST_STOP_CNT)) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_launch           = (r_state == S_IDLE) && (w_next_state == S_START);
  assign w_frame_end        = (r_state == S_STOP) && (w_next_state == S_IDLE);
  assign changed_tx_state_o = baud_tick_i && (w_next_state != r_state);

`ifdef UART_TX_PREFETCH_EN
  logic [7:0] r_hold_data;
  logic       r_hold_crc;
  logic       r_hold_par;
  logic       r_hold_full;
  logic       w_transfer;
  logic       w_frame_free;
  logic       w_drain;

  // The frame register is free only in IDLE with no launch outstanding;
  // otherwise an accepted byte parks in the holding register.
  assign tx_ready_o   = !rst_i && !r_hold_full;
  assign w_transfer   = tx_valid_i && tx_ready_o;
  assign w_frame_free = (r_state == S_IDLE) && !r_pending;
  assign w_drain      = r_hold_full && (w_frame_end || w_frame_free);
  assign w_load_frame = w_drain || (w_transfer && w_frame_free);
  assign w_load_data  = r_hold_full ? r_hold_data : tx_data_i;
  assign w_load_crc   = r_hold_full ? r_hold_crc  : crc_en_i;
  assign w_load_par   = r_hold_full ? r_hold_par  : parity_en_i;

  // Holding register: fills on a transfer while busy, empties into the frame register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_data <= 8'h00;
      r_hold_crc  <= 1'b0;
      r_hold_par  <= 1'b0;
      r_hold_full <= 1'b0;
    end else if (w_transfer && !w_frame_free) begin
      r_hold_data <= tx_data_i;
      r_hold_crc  <= crc_en_i;
      r_hold_par  <= parity_en_i;
      r_hold_full <= 1'b1;
    end else if (w_drain) begin
      r_hold_full <= 1'b0;
    end
  end
`else
  assign tx_ready_o   = !rst_i && (r_state == S_IDLE) && !r_pending;
  assign w_load_frame = tx_valid_i && tx_ready_o;
  assign w_load_data  = tx_data_i;
  assign w_load_crc   = crc_en_i;
  assign w_load_par   = parity_en_i;
`endif

  // Frame register and launch bookkeeping; the start command follows a load by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data      <= 8'h00;
      r_crc_en    <= 1'b0;
      r_par_q     <= 1'b0;
      r_pending   <= 1'b0;
      r_start_cmd <= 1'b0;
    end else begin
      r_start_cmd <= w_load_frame;
      if (w_load_frame) begin
        r_data    <= w_load_data;
        r_crc_en  <= w_load_crc;
        r_par_q   <= w_load_par;
        r_pending <= 1'b1;
      end else if (w_launch) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Frame FSM with registered one-hot flags and end-of-frame pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_is_idle    <= 1'b1;
      r_is_start   <= 1'b0;
      r_is_data    <= 1'b0;
      r_is_parity  <= 1'b0;
      r_is_crc     <= 1'b0;
      r_is_stop    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_is_idle    <= (w_next_state == S_IDLE);
      r_is_start   <= (w_next_state == S_START);
      r_is_data    <= (w_next_state == S_DATA);
      r_is_parity  <= (w_next_state == S_PARITY);
      r_is_crc     <= (w_next_state == S_CRC);
      r_is_stop    <= (w_next_state == S_STOP);
      r_frame_done <= w_frame_end;
    end
  end

  assign data_o         = r_data;
  assign crc_en_o       = r_crc_en;
  assign tx_start_cmd_o = r_start_cmd;
  assign is_idle_o      = r_is_idle;
  assign is_start_o     = r_is_start;
  assign is_data_o      = r_is_data;
  assign is_parity_o    = r_is_parity;
  assign is_crc_o       = r_is_crc;
  assign is_stop_o      = r_is_stop;
  assign frame_done_o   = r_frame_done;

endmodule
